sig_round_pipe: RTL and testbench
=================================

// Module: sig_round_pipe
// PURPOSE
// Two-stage pipelined significand rounder and post-normaliser directly upstream of exponent rounding.
// Takes sign, biased exponent and guard/sticky-extended significand from the normaliser.
// Produces s/e3/f3/OVF in the exact form exponent rounding consumes.
// Valid/ready handshake on both sides; full throughput under no backpressure.
// PARAMETERS
// EIN_W   13  width of signed biased input exponent e2 (two's complement)
// PIPE2   1   1: add/post-normalise registered in stage 2 (latency 2); 0: stage 2 combinational (latency 1)
// PORTS
// clk        in   1    clock, rising edge
// rst_n      in   1    reset, asynchronous, active-low
// in_valid   in   1    input beat valid
// in_ready   out  1    block can accept beat
// s          in   1    sign
// e2         in   EIN_W biased exponent, >=1 (denormals pre-shifted to e2=1)
// f2         in   56   [55] hidden, [54:3] fraction, [2] round, [1:0] sticky source (double layout)
// RM         in   2    00 RZ, 01 RNE, 10 toward +inf, 11 toward -inf
// db         in   1    1 double, 0 single
// out_valid  out  1    output beat valid
// out_ready  in   1    consumer accepts
// s_o        out  1    sign passthrough
// e3         out  11   rounded exponent [10:0]
// f3         out  53   rounded significand incl. hidden bit [52]
// OVF        out  1    rounded exponent >= 2047 (db) / >= 255 (single)
// RM_o,db_o  out  2,1  passthrough for downstream overflow/infinity selection
// BEHAVIOUR
// - Reset: out_valid=0, in_ready=1 once rst_n high, all data outputs 0; async assert, sync-deassert assumed from top.
// - Stage 1 (register on in_valid&in_ready): LSB/round/sticky extraction, increment decision inc.
//   db=1: L=f2[3], r=f2[2], st=|f2[1:0], keep f2[55:3].
//   db=0: L=f2[32], r=f2[31], st=|f2[30:0], keep f2[55:32], lower significand bits forced 0.
//   inc: RZ 0; RNE r&(L|st); +inf ~s&(r|st); -inf s&(r|st).
// - Stage 2: sum = kept + inc at LSB position (54-bit with carry).
//   Carry-out: f3 = 1.000..0, exponent e2+1.
//   Denormal e2=1, f2[55]=0 rounding into hidden bit: f3[52]=1, e unchanged.
// - OVF when rounded exponent >= 2047 (db=1) / 255 (db=0), compare at EIN_W width; e3 = low 11 bits, no saturation.
// - Handshake: stage advances when its successor is empty or advancing.
//   in_ready = ~s1_v | (s1 advancing); out_valid = s2_v.
//   Output data stable while out_valid & ~out_ready.
//   Simultaneous accept and emit in one cycle allowed; no bubbles under continuous valid/ready.
// - Latency: 2 cycles (PIPE2=1) / 1 cycle (PIPE2=0) from accepted input to out_valid.
// - Reset mid-operation drops all in-flight beats; no partial beat appears after reset.
// - Data registers do not load on non-accepted cycles; X on inputs with in_valid=0 must not propagate.
// CONFIGURATION
// SIGRND_INEXACT_EN defined: adds output INX (1 bit), INX = r|st of the beat, pipelined alongside f3, reset 0.
// Not defined: port absent, r/st not carried past stage 1 beyond inc.
// TESTING
// db=1,RNE,s=0,e2=1023,f2[55:3]=all ones,r=1,st=0 -> f3=1<<52, e3=1024, OVF=0, 2 cycles later
// db=1,RNE,L=0,r=1,st=0 -> no increment (tie to even); L=1 -> +1 ulp
// db=0,+inf,s=0,e2=254,f2[55:32]=all ones,st=1 -> e3=255, OVF=1, f3=1<<52
// db=1,-inf,s=0,r=1 -> no increment; s=1 -> increment
// e2=1,f2[55]=0,f2[54:3]=all ones,RNE,r=1,st=1 -> f3[52]=1, e3=1
// out_ready low 5 cycles with 4 beats offered -> 2 held (PIPE2=1), in_ready=0, order and values preserved, then 1 beat/cycle

Source files
------------

// File: rtl/sig_round_pipe.sv
// Pipelined significand rounder and post-normaliser: it extracts L/r/st and makes the increment decision, then adds and renormalises.
// Optional build macro SIGRND_INEXACT_EN adds the INX output, which carries r|st of the beat.
module sig_round_pipe #(
  parameter int EIN_W = 13,
  parameter bit PIPE2 = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             s,
  input  logic [EIN_W-1:0] e2,
  input  logic [55:0]      f2,
  input  logic [1:0]       RM,
  input  logic             db,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             s_o,
  output logic [10:0]      e3,
  output logic [52:0]      f3,
  output logic             OVF,
  output logic [1:0]       RM_o,
  output logic             db_o
`ifdef SIGRND_INEXACT_EN
  ,
  output logic             INX
`endif
);

  localparam logic [52:0] HIDDEN_ONE = 53'h10000000000000;
  localparam logic [52:0] ULP_DB     = 53'd1;
  localparam logic [52:0] ULP_SG     = 53'h00000020000000;
  localparam logic signed [EIN_W-1:0] EMAX_DB = EIN_W'(2047);
  localparam logic signed [EIN_W-1:0] EMAX_SG = EIN_W'(255);

  // Stage 1: LSB / round / sticky extraction and the increment decision
  logic        lsb, rnd, stk, inc_d;
  logic [52:0] kept_d;

  always_comb begin
    if (db) begin
      lsb    = f2[3];
      rnd    = f2[2];
      stk    = |f2[1:0];
      kept_d = f2[55:3];
    end else begin
      lsb    = f2[32];
      rnd    = f2[31];
      stk    = |f2[30:0];
      kept_d = {f2[55:32], 29'd0};
    end
    case (RM)
      2'b00:   inc_d = 1'b0;
      2'b01:   inc_d = rnd & (lsb | stk);
      2'b10:   inc_d = ~s & (rnd | stk);
      default: inc_d = s & (rnd | stk);
    endcase
  end

  logic             s1_v_q, s1_s_q, s1_inc_q, s1_db_q;
  logic [EIN_W-1:0] s1_e_q;
  logic [52:0]      s1_kept_q;
  logic [1:0]       s1_rm_q;
  logic             s1_load, s1_adv;

  assign in_ready = ~s1_v_q | s1_adv;
  assign s1_load  = in_valid & in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_v_q <= 1'b0;
    end else begin
      s1_v_q <= s1_load | (s1_v_q & ~s1_adv);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_s_q    <= 1'b0;
      s1_e_q    <= '0;
      s1_kept_q <= '0;
      s1_inc_q  <= 1'b0;
      s1_rm_q   <= 2'b00;
      s1_db_q   <= 1'b0;
    end else if (s1_load) begin
      s1_s_q    <= s;
      s1_e_q    <= e2;
      s1_kept_q <= kept_d;
      s1_inc_q  <= inc_d;
      s1_rm_q   <= RM;
      s1_db_q   <= db;
    end
  end

`ifdef SIGRND_INEXACT_EN
  logic s1_inx_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_inx_q <= 1'b0;
    end else if (s1_load) begin
      s1_inx_q <= rnd | stk;
    end
  end
`endif

  // Stage 2: add at the format LSB; a carry out of the hidden bit renormalises to 1.0 and bumps the exponent
  logic [53:0]      sum;
  logic             carry;
  logic [52:0]      f3_d;
  logic [EIN_W-1:0] e_rnd;
  logic             ovf_d;

  assign sum   = {1'b0, s1_kept_q} + {1'b0, (s1_inc_q ? (s1_db_q ? ULP_DB : ULP_SG) : 53'd0)};
  assign carry = sum[53];
  assign f3_d  = carry ? HIDDEN_ONE : sum[52:0];
  assign e_rnd = s1_e_q + EIN_W'(carry);
  assign ovf_d = $signed(e_rnd) >= (s1_db_q ? EMAX_DB : EMAX_SG);

  if (PIPE2) begin : g_stage2_reg
    logic        s2_v_q, s2_s_q, s2_ovf_q, s2_db_q;
    logic [10:0] s2_e_q;
    logic [52:0] s2_f_q;
    logic [1:0]  s2_rm_q;

    assign s1_adv = s1_v_q & (~s2_v_q | out_ready);

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        s2_v_q <= 1'b0;
      end else if (~s2_v_q | out_ready) begin
        s2_v_q <= s1_v_q;
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        s2_s_q   <= 1'b0;
        s2_e_q   <= '0;
        s2_f_q   <= '0;
        s2_ovf_q <= 1'b0;
        s2_rm_q  <= 2'b00;
        s2_db_q  <= 1'b0;
      end else if (s1_adv) begin
        s2_s_q   <= s1_s_q;
        s2_e_q   <= e_rnd[10:0];
        s2_f_q   <= f3_d;
        s2_ovf_q <= ovf_d;
        s2_rm_q  <= s1_rm_q;
        s2_db_q  <= s1_db_q;
      end
    end

    assign out_valid = s2_v_q;
    assign s_o       = s2_s_q;
    assign e3        = s2_e_q;
    assign f3        = s2_f_q;
    assign OVF       = s2_ovf_q;
    assign RM_o      = s2_rm_q;
    assign db_o      = s2_db_q;

`ifdef SIGRND_INEXACT_EN
    logic s2_inx_q;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        s2_inx_q <= 1'b0;
      end else if (s1_adv) begin
        s2_inx_q <= s1_inx_q;
      end
    end
    assign INX = s2_inx_q;
`endif
  end else begin : g_stage2_comb
    assign s1_adv    = s1_v_q & out_ready;
    assign out_valid = s1_v_q;
    assign s_o       = s1_s_q;
    assign e3        = e_rnd[10:0];
    assign f3        = f3_d;
    assign OVF       = ovf_d;
    assign RM_o      = s1_rm_q;
    assign db_o      = s1_db_q;
`ifdef SIGRND_INEXACT_EN
    assign INX = s1_inx_q;
`endif
  end

endmodule

// File: tb/tb_sig_round_pipe.sv
// Directed-vector bench for sig_round_pipe (default PIPE2=1): rounding cases, throughput, backpressure, reset.
module tb_sig_round_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic        s, db, s_o, OVF, db_o;
  logic [12:0] e2;
  logic [55:0] f2;
  logic [1:0]  RM, RM_o;
  logic [10:0] e3;
  logic [52:0] f3;
`ifdef SIGRND_INEXACT_EN
  logic        inx;
`endif

  sig_round_pipe #(.EIN_W(13), .PIPE2(1'b1)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .s(s), .e2(e2), .f2(f2), .RM(RM), .db(db),
    .out_valid(out_valid), .out_ready(out_ready),
    .s_o(s_o), .e3(e3), .f3(f3), .OVF(OVF), .RM_o(RM_o), .db_o(db_o)
`ifdef SIGRND_INEXACT_EN
    , .INX(inx)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        s;
    logic [12:0] e2;
    logic [55:0] f2;
    logic [1:0]  rm;
    logic        db;
    logic [10:0] e3;
    logic [52:0] f3;
    logic        ovf;
  } vec_t;

  localparam int NV = 15;
  localparam logic [52:0] H = 53'h10000000000000;
  vec_t vecs [NV];
  int   checks = 0;
  int   errors = 0;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_vec(input int i, input logic vs, input logic [12:0] ve2, input logic [55:0] vf2,
                         input logic [1:0] vrm, input logic vdb, input logic [10:0] ve3,
                         input logic [52:0] vf3, input logic vovf);
    vecs[i].s = vs;  vecs[i].e2 = ve2; vecs[i].f2 = vf2; vecs[i].rm = vrm;
    vecs[i].db = vdb; vecs[i].e3 = ve3; vecs[i].f3 = vf3; vecs[i].ovf = vovf;
  endtask

  task automatic drive(input int i);
    s = vecs[i].s; e2 = vecs[i].e2; f2 = vecs[i].f2; RM = vecs[i].rm; db = vecs[i].db;
  endtask

  task automatic drive_junk();
    s = 1'b1; e2 = '1; f2 = '1; RM = 2'b11; db = 1'b1;
  endtask

  // Offers beats first..first+n-1 back to back; out_ready held low for the first `stall` cycles.
  task automatic run_stream(input int first, input int n, input int stall, input int exp_cyc);
    int idx, got, cyc, k;
    idx = 0; got = 0; cyc = 0;
    while (got < n && cyc < 100) begin
      in_valid = (idx < n);
      if (idx < n) drive(first + idx); else drive_junk();
      out_ready = (cyc >= stall);
      #1;
      if (stall > 2 && cyc == stall - 1) begin
        check_val("held_beats", idx, 2);
        check_val("held_in_ready", in_ready, 0);
        check_val("held_out_valid", out_valid, 1);
      end
      if (out_valid && out_ready) begin
        k = first + got;
        $display("beat %0d: s=%0b e3=%0d f3=%h OVF=%0b RM=%0d db=%0b", k, s_o, e3, f3, OVF, RM_o, db_o);
        check_val("e3", e3, vecs[k].e3);
        check_val("f3", f3, vecs[k].f3);
        check_val("OVF", OVF, vecs[k].ovf);
        check_val("s_o", s_o, vecs[k].s);
        check_val("RM_o", RM_o, vecs[k].rm);
        check_val("db_o", db_o, vecs[k].db);
        got++;
      end
      if (in_valid && in_ready) idx++;
      @(negedge clk);
      cyc++;
    end
    in_valid = 1'b0;
    drive_junk();
    check_val("stream_beats", got, n);
    check_val("stream_cycles", cyc, exp_cyc);
  endtask

  initial begin
    int seen;
    //       i  s  e2    f2                                 RM     db    e3     f3                     OVF
    set_vec(0,  0, 1023, {53'h1FFFFFFFFFFFFF, 3'b100},       2'b01, 1'b1, 1024,  H,                     0);
    set_vec(1,  0, 100,  {H, 3'b100},                        2'b01, 1'b1, 100,   H,                     0);
    set_vec(2,  0, 100,  {53'h10000000000001, 3'b100},       2'b01, 1'b1, 100,   53'h10000000000002,    0);
    set_vec(3,  0, 254,  {24'hFFFFFF, 32'h00000001},         2'b10, 1'b0, 255,   H,                     1);
    set_vec(4,  0, 500,  {H, 3'b100},                        2'b11, 1'b1, 500,   H,                     0);
    set_vec(5,  1, 500,  {H, 3'b100},                        2'b11, 1'b1, 500,   53'h10000000000001,    0);
    set_vec(6,  0, 1,    {53'h0FFFFFFFFFFFFF, 3'b111},       2'b01, 1'b1, 1,     H,                     0);
    set_vec(7,  0, 2046, {53'h1ABCDEF0123456, 3'b111},       2'b00, 1'b1, 2046,  53'h1ABCDEF0123456,    0);
    set_vec(8,  0, 2046, {53'h1FFFFFFFFFFFFF, 3'b100},       2'b01, 1'b1, 2047,  H,                     1);
    set_vec(9,  0, 127,  {24'h800000, 32'h80000000},         2'b01, 1'b0, 127,   H,                     0);
    set_vec(10, 0, 127,  {24'h800001, 32'h80000000},         2'b01, 1'b0, 127,   53'h10000040000000,    0);
    set_vec(11, 1, 254,  {24'hFFFFFF, 32'h00000001},         2'b10, 1'b0, 254,   53'h1FFFFFE0000000,    0);
    set_vec(12, 0, 2100, {H, 3'b000},                        2'b00, 1'b1, 52,    H,                     1);
    set_vec(13, 0, 300,  {53'h10000000000003, 3'b000},       2'b10, 1'b1, 300,   53'h10000000000003,    0);
    set_vec(14, 0, 10,   {24'h800001, 32'h00000001},         2'b01, 1'b0, 10,    53'h10000020000000,    0);

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    drive_junk();
    repeat (3) @(negedge clk);
    check_val("rst_out_valid", out_valid, 0);
    check_val("rst_e3", e3, 0);
    check_val("rst_f3", f3, 0);
    check_val("rst_OVF", OVF, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check_val("rst_in_ready", in_ready, 1);
    check_val("idle_out_valid", out_valid, 0);

    run_stream(0, 1, 0, 3);
    run_stream(1, NV - 1, 0, NV + 1);
    run_stream(0, 4, 5, 9);

    out_ready = 1'b0;
    in_valid  = 1'b1;
    drive(0);
    @(negedge clk);
    drive(1);
    @(negedge clk);
    in_valid = 1'b0;
    drive_junk();
    check_val("pre_rst_valid", out_valid, 1);
    rst_n = 1'b0;
    #1;
    check_val("mid_rst_out_valid", out_valid, 0);
    check_val("mid_rst_f3", f3, 0);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    seen = 0;
    repeat (4) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    check_val("post_rst_no_beat", seen, 0);
    run_stream(5, 3, 0, 5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
